// File: rtl/variable_delay_cal.sv
// Delay-line calibration sequencer: sweeps sel, settles, checks a training window, locks or fails.
// Optional VD_CAL_RETRAIN_EN: restart the sweep after err_limit consecutive mismatches while locked.
module variable_delay_cal #(
  parameter int sel_width = 4,
  parameter int width     = 8,
  parameter int settle    = 48,
  parameter int window    = 64,
  parameter int err_limit = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ce,
  input  logic                 start,
  input  logic [width-1:0]     din,
  input  logic [width-1:0]     exp,
  output logic [sel_width-1:0] sel,
  output logic                 busy,
  output logic                 locked,
  output logic                 fail
);

  localparam int SCW = $clog2(settle) + 1;
  localparam int MCW = $clog2(window) + 1;

  localparam logic [sel_width-1:0] SEL_MAX  = '1;
  localparam logic [SCW-1:0]       SETTLE_L = SCW'(settle - 1);
  localparam logic [MCW-1:0]       WIN_L    = MCW'(window - 1);

  if (window < 1) begin : g_bad_window
    $error("window must be >= 1");
  end
  if (err_limit < 1) begin : g_bad_err_limit
    $error("err_limit must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_NEXT,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t         state;
  logic [SCW-1:0] scnt;
  logic [MCW-1:0] mcnt;
  logic           hit;
  logic           req;
  logic           trip;
  logic           go;

  assign hit = (din == exp);
  assign req = start && (state == S_IDLE ||
                         state == S_LOCKED ||
                         state == S_FAIL);

`ifdef VD_CAL_RETRAIN_EN
  localparam int ECW = $clog2(err_limit) + 1;
  localparam logic [ECW-1:0] ERR_L = ECW'(err_limit - 1);

  logic [ECW-1:0] ecnt;

  assign trip = (state == S_LOCKED) && ce &&
                !hit && (ecnt == ERR_L);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ecnt <= '0;
    end else if (go || state != S_LOCKED) begin
      ecnt <= '0;
    end else if (ce) begin
      if (hit) ecnt <= '0;
      else     ecnt <= ecnt + ECW'(1);
    end
  end
`else
  assign trip = 1'b0;
`endif

  // A retrain trip behaves exactly like a fresh start request
  assign go = req || trip;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      sel    <= '0;
      busy   <= 1'b0;
      locked <= 1'b0;
      fail   <= 1'b0;
      scnt   <= '0;
      mcnt   <= '0;
    end else if (go) begin
      state  <= S_SETTLE;
      sel    <= '0;
      busy   <= 1'b1;
      locked <= 1'b0;
      fail   <= 1'b0;
      scnt   <= '0;
      mcnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_LOCKED, S_FAIL: begin
          state <= state;
        end
        S_SETTLE: begin
          if (ce) begin
            scnt <= scnt + SCW'(1);
            if (scnt == SETTLE_L) begin
              state <= S_MEASURE;
              mcnt  <= '0;
            end
          end
        end
        S_MEASURE: begin
          if (ce) begin
            if (!hit) begin
              state <= S_NEXT;
            end else begin
              mcnt <= mcnt + MCW'(1);
              if (mcnt == WIN_L) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
                busy   <= 1'b0;
              end
            end
          end
        end
        S_NEXT: begin
          if (sel == SEL_MAX) begin
            state <= S_FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
            sel   <= '0;
          end else begin
            sel   <= sel + sel_width'(1);
            scnt  <= '0;
            state <= S_SETTLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
